// File: rtl/serial_bit_src_if.sv
// Handshake bundle for serial_bit_src: parallel word in, single bit out.
// The slave modport is the serializer; master is the word producer / bit consumer side.
interface serial_bit_src_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             out_bit;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_bit, out_valid, out_last
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_bit, out_valid, out_last
   );
endinterface

// File: rtl/serial_bit_src.sv
// Parallel-to-serial bit source: LSB-first data bits, optional even-parity trailer,
// valid/ready backpressure, synchronous flush and a wrapping completed-frame counter.
module serial_bit_src #(
   parameter int          WIDTH     = 8,
   parameter int unsigned PARITY_EN = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 flush,
   serial_bit_src_if.slave      bus,
   output logic [7:0]           frame_cnt
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_e;

   function automatic logic even_parity(input logic [WIDTH-1:0] d);
      return ^d;
   endfunction

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             par_q, par_d;
   logic [7:0]       frame_cnt_q, frame_cnt_d;

   logic             in_ready_s;
   logic             out_valid_s;
   logic             out_bit_s;
   logic             out_last_s;

   // State register; reset forces IDLE and clears all datapath state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         par_q       <= 1'b0;
         frame_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         par_q       <= par_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Next-state and output decode; outputs depend only on registered state.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      par_d       = par_q;
      frame_cnt_d = frame_cnt_q;
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      out_bit_s   = 1'b0;
      out_last_s  = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready_s = 1'b1;
            if (bus.in_valid) begin
               shift_d = bus.in_data;
               cnt_d   = '0;
               par_d   = even_parity(bus.in_data);
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            out_valid_s = 1'b1;
            out_bit_s   = shift_q[0];
            out_last_s  = (PARITY_EN == 0) && (cnt_q == LAST_IDX);
            if (bus.out_ready) begin
               shift_d = shift_q >> 1;
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_IDX) begin
                  if (PARITY_EN != 0) begin
                     state_d = PARITY;
                  end else begin
                     state_d     = IDLE;
                     frame_cnt_d = frame_cnt_q + 8'd1;
                  end
               end else begin
                  state_d = SHIFT;
               end
            end else begin
               state_d = SHIFT;
            end
         end
         PARITY: begin
            out_valid_s = 1'b1;
            out_bit_s   = par_q;
            out_last_s  = 1'b1;
            if (bus.out_ready) begin
               state_d     = IDLE;
               frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
               state_d = PARITY;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Flush overrides any acceptance or final-bit transfer decided above.
      if (flush) begin
         state_d     = IDLE;
         shift_d     = shift_q;
         cnt_d       = cnt_q;
         par_d       = par_q;
         frame_cnt_d = frame_cnt_q;
      end else begin
         frame_cnt_d = frame_cnt_d;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.out_bit   = out_bit_s;
   assign bus.out_last  = out_last_s;
   assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_serial_bit_src.sv
// Scoreboard bench for serial_bit_src: one parity-enabled and one parity-less instance.
module tb_serial_bit_src;
   localparam int W = 8;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       flush;
   logic [7:0] frame_cnt;
   logic [7:0] np_frame_cnt;

   serial_bit_src_if #(.WIDTH(W)) bif ();
   serial_bit_src_if #(.WIDTH(W)) nif ();

   serial_bit_src #(.WIDTH(W), .PARITY_EN(1)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bif), .frame_cnt(frame_cnt)
   );
   serial_bit_src #(.WIDTH(W), .PARITY_EN(0)) dut_np (
      .clk(clk), .reset_n(reset_n), .flush(flush), .bus(nif), .frame_cnt(np_frame_cnt)
   );

   always #5 clk = ~clk;

   int         n_pass  = 0;
   int         n_total = 0;
   logic [1:0] exp_q[$];   // {last, bit}
   logic [1:0] e;
   logic [7:0] exp_cnt;
   logic [7:0] exp_np_cnt;

   task automatic push_frame(input logic [W-1:0] d, input bit par_en);
      for (int i = 0; i < W; i++)
         exp_q.push_back({(!par_en && (i == W - 1)), d[i]});
      if (par_en)
         exp_q.push_back({1'b1, ^d});
   endtask

   task automatic test_reset();
      reset_n = 1'b1; flush = 1'b0;
      bif.in_data = 8'h00; bif.in_valid = 1'b0; bif.out_ready = 1'b1;
      nif.in_data = 8'h00; nif.in_valid = 1'b0; nif.out_ready = 1'b1;
      #2 reset_n = 1'b0;
      #10;
      n_total++; if (bif.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bif.in_ready); else n_pass++;
      n_total++; if ({bif.out_valid, bif.out_bit, bif.out_last} !== 3'b000)
         $display("FAIL reset_outputs got %b want 000", {bif.out_valid, bif.out_bit, bif.out_last}); else n_pass++;
      n_total++; if (frame_cnt !== 8'h00) $display("FAIL reset_frame_cnt got %h want 00", frame_cnt); else n_pass++;
      n_total++; if (nif.in_ready !== 1'b1) $display("FAIL reset_np_in_ready got %b want 1", nif.in_ready); else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      exp_cnt = 8'h00; exp_np_cnt = 8'h00;
   endtask

   task automatic test_basic();
      @(negedge clk);
      n_total++; if (bif.in_ready !== 1'b1) $display("FAIL basic_ready got %b want 1", bif.in_ready); else n_pass++;
      bif.in_data = 8'hA5; bif.in_valid = 1'b1; bif.out_ready = 1'b1;
      push_frame(8'hA5, 1'b1);
      @(negedge clk);
      bif.in_valid = 1'b0;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         bif.in_data = 8'($urandom);
         n_total++;
         if (bif.out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", bif.out_valid);
         else begin
            n_pass++;
            e = exp_q.pop_front();
            n_total++;
            if ({bif.out_last, bif.out_bit} !== e) $display("FAIL basic_bit got %b want %b", {bif.out_last, bif.out_bit}, e); else n_pass++;
         end
         @(negedge clk);
      end
      exp_cnt++;
      n_total++; if (exp_q.size() != 0) $display("FAIL basic_timeout got %0d left want 0", exp_q.size()); else n_pass++;
      n_total++; if (frame_cnt !== exp_cnt) $display("FAIL basic_frame_cnt got %h want %h", frame_cnt, exp_cnt); else n_pass++;
      n_total++; if ({bif.in_ready, bif.out_valid} !== 2'b10) $display("FAIL basic_idle got %b want 10", {bif.in_ready, bif.out_valid}); else n_pass++;
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      int k = 0;
      int stall = 0;
      @(negedge clk);
      bif.in_data = 8'h03; bif.in_valid = 1'b1;
      push_frame(8'h03, 1'b1);
      @(negedge clk);
      bif.in_valid = 1'b0;
      for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
         if (k == 1 && stall < 5) begin bif.out_ready = 1'b0; stall++; end
         else bif.out_ready = 1'b1;
         n_total++;
         if ({bif.out_valid, bif.out_last, bif.out_bit} !== {1'b1, exp_q[0]})
            $display("FAIL bp_bit got %b want %b", {bif.out_valid, bif.out_last, bif.out_bit}, {1'b1, exp_q[0]});
         else n_pass++;
         if (bif.out_ready) begin void'(exp_q.pop_front()); k++; end
         @(negedge clk);
      end
      bif.out_ready = 1'b1;
      exp_cnt++;
      n_total++; if (exp_q.size() != 0 || stall != 5) $display("FAIL bp_timeout got %0d left want 0", exp_q.size()); else n_pass++;
      n_total++; if (frame_cnt !== exp_cnt) $display("FAIL bp_frame_cnt got %h want %h", frame_cnt, exp_cnt); else n_pass++;
      exp_q.delete();
   endtask

   task automatic test_flush();
      @(negedge clk);
      bif.in_data = 8'hFF; bif.in_valid = 1'b1; bif.out_ready = 1'b1;
      push_frame(8'hFF, 1'b1);
      @(negedge clk);
      bif.in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         e = exp_q.pop_front();
         n_total++;
         if ({bif.out_valid, bif.out_last, bif.out_bit} !== {1'b1, e})
            $display("FAIL flush_pre_bit got %b want %b", {bif.out_valid, bif.out_last, bif.out_bit}, {1'b1, e});
         else n_pass++;
         @(negedge clk);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      exp_q.delete();
      n_total++; if ({bif.in_ready, bif.out_valid} !== 2'b10) $display("FAIL flush_idle got %b want 10", {bif.in_ready, bif.out_valid}); else n_pass++;
      n_total++; if (frame_cnt !== exp_cnt) $display("FAIL flush_frame_cnt got %h want %h", frame_cnt, exp_cnt); else n_pass++;
      // Flush together with an acceptance: the word must be dropped.
      bif.in_data = 8'h5A; bif.in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; bif.in_valid = 1'b0;
      n_total++; if ({bif.in_ready, bif.out_valid} !== 2'b10) $display("FAIL flush_accept got %b want 10", {bif.in_ready, bif.out_valid}); else n_pass++;
      // Flush on the parity (last) bit transfer: no count.
      bif.in_data = 8'h0F; bif.in_valid = 1'b1;
      @(negedge clk);
      bif.in_valid = 1'b0;
      repeat (8) @(negedge clk);
      n_total++; if ({bif.out_valid, bif.out_last} !== 2'b11) $display("FAIL flush_last_pos got %b want 11", {bif.out_valid, bif.out_last}); else n_pass++;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_total++; if (frame_cnt !== exp_cnt) $display("FAIL flush_last_cnt got %h want %h", frame_cnt, exp_cnt); else n_pass++;
      n_total++; if ({bif.in_ready, bif.out_valid} !== 2'b10) $display("FAIL flush_last_idle got %b want 10", {bif.in_ready, bif.out_valid}); else n_pass++;
   endtask

   task automatic test_no_parity();
      @(negedge clk);
      nif.in_data = 8'h80; nif.in_valid = 1'b1; nif.out_ready = 1'b1;
      push_frame(8'h80, 1'b0);
      @(negedge clk);
      nif.in_valid = 1'b0;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         nif.in_data = 8'($urandom);
         e = exp_q.pop_front();
         n_total++;
         if ({nif.out_valid, nif.out_last, nif.out_bit} !== {1'b1, e})
            $display("FAIL np_bit got %b want %b", {nif.out_valid, nif.out_last, nif.out_bit}, {1'b1, e});
         else n_pass++;
         @(negedge clk);
      end
      exp_np_cnt++;
      n_total++; if ({nif.in_ready, nif.out_valid, nif.out_last} !== 3'b100)
         $display("FAIL np_idle got %b want 100", {nif.in_ready, nif.out_valid, nif.out_last}); else n_pass++;
      n_total++; if (np_frame_cnt !== exp_np_cnt) $display("FAIL np_frame_cnt got %h want %h", np_frame_cnt, exp_np_cnt); else n_pass++;
      exp_q.delete();
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      bif.in_data = 8'h3C; bif.in_valid = 1'b1; bif.out_ready = 1'b1;
      @(negedge clk);
      bif.in_valid = 1'b0;
      @(negedge clk);
      n_total++; if (bif.out_valid !== 1'b1) $display("FAIL areset_mid got %b want 1", bif.out_valid); else n_pass++;
      #2 reset_n = 1'b0;
      #1;
      n_total++; if ({bif.in_ready, bif.out_valid, bif.out_bit, bif.out_last} !== 4'b1000)
         $display("FAIL areset_outputs got %b want 1000", {bif.in_ready, bif.out_valid, bif.out_bit, bif.out_last}); else n_pass++;
      n_total++; if (frame_cnt !== 8'h00) $display("FAIL areset_frame_cnt got %h want 00", frame_cnt); else n_pass++;
      n_total++; if (np_frame_cnt !== 8'h00) $display("FAIL areset_np_cnt got %h want 00", np_frame_cnt); else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      exp_cnt = 8'h00; exp_np_cnt = 8'h00;
      @(negedge clk);
      n_total++; if ({bif.in_ready, bif.out_valid} !== 2'b10) $display("FAIL areset_after got %b want 10", {bif.in_ready, bif.out_valid}); else n_pass++;
   endtask

   task automatic test_back_to_back_wrap();
      bif.in_valid = 1'b1; bif.out_ready = 1'b1;
      for (int f = 0; f < 256; f++) begin
         n_total++; if (bif.in_ready !== 1'b1) $display("FAIL b2b_ready frame %0d got %b want 1", f, bif.in_ready); else n_pass++;
         bif.in_data = 8'($urandom);
         repeat (W + 2) @(negedge clk);
         exp_cnt++;
         n_total++; if (frame_cnt !== exp_cnt) $display("FAIL wrap_cnt frame %0d got %h want %h", f, frame_cnt, exp_cnt); else n_pass++;
         if (f == 254) begin
            n_total++; if (frame_cnt !== 8'hFF) $display("FAIL wrap_ff got %h want ff", frame_cnt); else n_pass++;
         end
         if (f == 255) begin
            n_total++; if (frame_cnt !== 8'h00) $display("FAIL wrap_00 got %h want 00", frame_cnt); else n_pass++;
         end
      end
      bif.in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_flush();
      test_no_parity();
      test_async_reset();
      test_back_to_back_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
